// File: rtl/mult.sv
// Sequential radix-2 Booth multiplier: 32x32 signed operands, 64-bit signed product.
// One Booth step per clock; a result is presented 32 cycles after the start request.
module mult (
    input  logic        clk,
    input  logic        Reset_Out,
    input  logic [31:0] A_Out,
    input  logic [31:0] B_Out,
    input  logic        MultInit,
    output logic        MultStop,
    output logic [31:0] Mult_High_Out,
    output logic [31:0] Mult_Low_Out
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t      state_q;
    logic [32:0] acc_q;
    logic [32:0] m_q;
    logic [31:0] q_q;
    logic        q_m1_q;
    logic [4:0]  cnt_q;

    logic [32:0] acc_sum;
    logic [32:0] acc_d;
    logic [31:0] q_d;

    // One Booth step: conditional add/subtract, then arithmetic shift of {acc, q, q[-1]}.
    always_comb begin
        acc_sum = acc_q;
        case ({q_q[0], q_m1_q})
            2'b01:   acc_sum = acc_q + m_q;
            2'b10:   acc_sum = acc_q - m_q;
            default: acc_sum = acc_q;
        endcase
        acc_d = {acc_sum[32], acc_sum[32:1]};
        q_d   = {acc_sum[0], q_q[31:1]};
    end

    always_ff @(posedge clk or negedge Reset_Out) begin
        if (!Reset_Out) begin
            state_q       <= StIdle;
            acc_q         <= '0;
            m_q           <= '0;
            q_q           <= '0;
            q_m1_q        <= 1'b0;
            cnt_q         <= '0;
            MultStop      <= 1'b0;
            Mult_High_Out <= '0;
            Mult_Low_Out  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (MultInit) begin
                        m_q     <= {A_Out[31], A_Out};
                        q_q     <= B_Out;
                        acc_q   <= '0;
                        q_m1_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    acc_q  <= acc_d;
                    q_q    <= q_d;
                    q_m1_q <= q_q[0];
                    cnt_q  <= cnt_q + 5'd1;
                    // The 32nd step lands straight in the output registers.
                    if (cnt_q == 5'd31) begin
                        Mult_High_Out <= acc_d[31:0];
                        Mult_Low_Out  <= q_d;
                        MultStop      <= 1'b1;
                        state_q       <= StDone;
                    end
                end
                StDone: begin
                    MultStop <= 1'b0;
                    state_q  <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult.sv
// Scoreboard bench for mult: the driver queues hand-computed products, and a monitor
// checks value, latency and strobe width whenever MultStop is seen.
module tb_mult;

    logic        clk;
    logic        Reset_Out;
    logic [31:0] A_Out;
    logic [31:0] B_Out;
    logic        MultInit;
    logic        MultStop;
    logic [31:0] Mult_High_Out;
    logic [31:0] Mult_Low_Out;

    mult dut (
        .clk           (clk),
        .Reset_Out     (Reset_Out),
        .A_Out         (A_Out),
        .B_Out         (B_Out),
        .MultInit      (MultInit),
        .MultStop      (MultStop),
        .Mult_High_Out (Mult_High_Out),
        .Mult_Low_Out  (Mult_Low_Out)
    );

    typedef struct {
        logic [63:0] prod;
        int          start;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    // Monitor: compare on every MultStop, and require it to be low one cycle later.
    initial begin
        exp_t e;
        bit   chk_low = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_low) begin
                check("stop_width", {63'd0, MultStop}, 64'd0);
                chk_low = 1'b0;
            end else if (MultStop) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_stop: MultStop high at cycle %0d, none expected",
                             cyc);
                end else begin
                    e = sb.pop_front();
                    check("product", {Mult_High_Out, Mult_Low_Out}, e.prod);
                    check("latency", 64'(cyc - e.start), 64'd32);
                    chk_low = 1'b1;
                end
            end
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] p);
        @(negedge clk);
        A_Out    = a;
        B_Out    = b;
        MultInit = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{prod: p, start: cyc});
        MultInit = 1'b0;
        A_Out    = ~a;
        B_Out    = ~b;
    endtask

    task automatic wait_done();
        int k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL timeout: %0d results outstanding, want 0", sb.size());
            sb.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, want finished", $time);
        $fatal(1, "timeout");
    end

    initial begin
        Reset_Out = 1'b0;
        A_Out     = 32'hDEAD_BEEF;
        B_Out     = 32'h1234_5678;
        MultInit  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_stop", {63'd0, MultStop}, 64'd0);
        check("rst_hi", {32'd0, Mult_High_Out}, 64'd0);
        check("rst_lo", {32'd0, Mult_Low_Out}, 64'd0);
        @(negedge clk);
        MultInit  = 1'b0;
        Reset_Out = 1'b1;

        run_op(32'd10, 32'd5, 64'h0000_0000_0000_0032);
        wait_done();
        check("hold_after_done", {Mult_High_Out, Mult_Low_Out}, 64'h32);

        // Outputs keep the previous result while a new operation runs.
        run_op(32'hFFFF_FFF9, 32'd3, 64'hFFFF_FFFF_FFFF_FFEB);
        repeat (2) @(posedge clk);
        #1;
        check("hold_during_run", {Mult_High_Out, Mult_Low_Out}, 64'h32);
        wait_done();

        run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
        wait_done();
        run_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        wait_done();
        run_op(32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);
        wait_done();

        // Operand change in the 5th RUN cycle is ignored.
        run_op(32'd6, 32'd7, 64'd42);
        repeat (4) @(posedge clk);
        #1;
        A_Out = 32'd100;
        wait_done();

        // Reset in the 10th RUN cycle aborts: outputs clear and no strobe follows.
        @(negedge clk);
        A_Out    = 32'd3;
        B_Out    = 32'd4;
        MultInit = 1'b1;
        @(posedge clk);
        #1;
        MultInit = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        Reset_Out = 1'b0;
        #1;
        check("abort_stop", {63'd0, MultStop}, 64'd0);
        check("abort_hi", {32'd0, Mult_High_Out}, 64'd0);
        check("abort_lo", {32'd0, Mult_Low_Out}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        Reset_Out = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_result", {Mult_High_Out, Mult_Low_Out}, 64'd0);

        run_op(32'hFFFF_FFFF, 32'h7FFF_FFFF, 64'hFFFF_FFFF_8000_0001);
        wait_done();

        // MultInit held high: back-to-back operations, one start every 34 cycles.
        @(negedge clk);
        A_Out    = 32'd10;
        B_Out    = 32'd5;
        MultInit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            sb.push_back('{prod: 64'd50, start: cyc});
            if (i < 2) repeat (33) @(posedge clk);
        end
        MultInit = 1'b0;
        wait_done();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
